// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, the
// wait-state limit, per-access operation flags and the window decode helper.
// The optional error flag is controlled by the macro DMEM_RESP_ERR_EN.
package dmem_responder_pkg;

    // Largest supported WAIT_STATES value and the counter width that holds it.
    localparam int WAIT_STATES_MAX = 15;
    localparam int CNT_BITS        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation flags captured with an access. When both r and w are
    // requested, the access is treated as a read, so wr is only ever set
    // for a pure write.
    typedef struct packed {
        logic rd;
        logic wr;
        logic hit;
    } op_t;

    // True when the address upper bits match the base window bits.
    function automatic logic in_window(input logic [15:0] adr,
                                       input logic [15:0] base,
                                       input int          adr_bits);
        return (adr >> adr_bits) == (base >> adr_bits);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Initiator/responder bus for the data-memory responder. The error flag
// only exists when DMEM_RESP_ERR_EN is defined.
interface dmem_responder_if;

    logic [15:0] d_mem_adr;
    logic        d_mem_r;
    logic        d_mem_w;
    logic [15:0] d_mem_wdata;
    logic [15:0] d_mem_rdata;
    logic        d_mem_rdy;

`ifdef DMEM_RESP_ERR_EN
    logic        d_mem_err;

    modport master (
        output d_mem_adr, d_mem_r, d_mem_w, d_mem_wdata,
        input  d_mem_rdata, d_mem_rdy, d_mem_err
    );

    modport slave (
        input  d_mem_adr, d_mem_r, d_mem_w, d_mem_wdata,
        output d_mem_rdata, d_mem_rdy, d_mem_err
    );
`else
    modport master (
        output d_mem_adr, d_mem_r, d_mem_w, d_mem_wdata,
        input  d_mem_rdata, d_mem_rdy
    );

    modport slave (
        input  d_mem_adr, d_mem_r, d_mem_w, d_mem_wdata,
        output d_mem_rdata, d_mem_rdy
    );
`endif

endinterface

// File: rtl/dmem_ram_sp.sv
// Single-port 2^ADR_BITS x 16 storage: synchronous write, combinational read
// on the same address port.
module dmem_ram_sp #(
    parameter int ADR_BITS = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADR_BITS-1:0] adr,
    input  logic [15:0]         wdata,
    output logic [15:0]         rdata
);

    logic [15:0] mem [0:(1 << ADR_BITS) - 1];

    // Commit a write on the rising edge when enabled.
    // NOTE: the storage array has no reset; contents survive a_rst and
    // clearing them would force a register-based implementation.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[adr] <= wdata;
        end
    end

    assign rdata = mem[adr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts a read or write request, waits WAIT_STATES
// cycles, then pulses d_mem_rdy for one cycle. Accesses outside the
// BASE_ADR window complete normally but read zero and drop writes.
// Define DMEM_RESP_ERR_EN to add the d_mem_err flag for out-of-window and
// simultaneous read/write accesses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          WAIT_STATES = 1,
    parameter int          ADR_BITS    = 8,
    parameter logic [15:0] BASE_ADR    = 16'h0000
) (
    input logic             clk,
    input logic             a_rst,
    dmem_responder_if.slave bus
);

    localparam int WS_CLAMPED = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
    localparam logic [CNT_BITS-1:0] WS_INIT = CNT_BITS'(WS_CLAMPED);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_t              state;
    logic [CNT_BITS-1:0] cnt;

    // Access captured when leaving IDLE.
    logic [ADR_BITS-1:0] cur_idx;
    logic [15:0]         cur_wdata;
    op_t                 cur_op;

    // Registered outputs.
    logic                rdy_q;
    logic [15:0]         rdata_q;

    // Live request decode and the access currently being serviced.
    logic                req_any;
    op_t                 req_op;
    logic [ADR_BITS-1:0] acc_idx;
    logic                acc_rd;
    logic                acc_hit;

    logic                go_resp;
    logic                ram_we;
    logic [15:0]         ram_q;

    // Decode the live bus request.
    always_comb begin
        req_any    = bus.d_mem_r | bus.d_mem_w;
        req_op.rd  = bus.d_mem_r;
        req_op.wr  = bus.d_mem_w & ~bus.d_mem_r;
        req_op.hit = in_window(bus.d_mem_adr, BASE_ADR, ADR_BITS);
    end

    // Select the access in flight: the live request while IDLE (needed for
    // the zero-wait path), otherwise the captured one.
    // NOTE: every output of a combinational block is assigned on every path,
    // so no latch is inferred.
    always_comb begin
        if (state == IDLE) begin
            acc_idx = bus.d_mem_adr[ADR_BITS-1:0];
            acc_rd  = req_op.rd;
            acc_hit = req_op.hit;
        end else begin
            acc_idx = cur_idx;
            acc_rd  = cur_op.rd;
            acc_hit = cur_op.hit;
        end
    end

    // Decide whether the next cycle is the RESP cycle, and whether the
    // storage write commits at the edge that ends RESP.
    always_comb begin
        go_resp = req_any &&
                  (((state == IDLE) && (WS_INIT == '0)) ||
                   ((state == WAIT) && (cnt <= CNT_ONE)));
        ram_we  = (state == RESP) && cur_op.wr && cur_op.hit;
    end

    dmem_ram_sp #(
        .ADR_BITS (ADR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .adr   (acc_idx),
        .wdata (cur_wdata),
        .rdata (ram_q)
    );

`ifdef DMEM_RESP_ERR_EN
    logic req_err;
    logic cur_err;
    logic acc_err;
    logic err_q;

    // Flag out-of-window and simultaneous read/write requests.
    always_comb begin
        req_err = ~req_op.hit | (bus.d_mem_r & bus.d_mem_w);
        acc_err = (state == IDLE) ? req_err : cur_err;
    end

    // Register the error flag so it is high only in the RESP cycle.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            err_q   <= 1'b0;
            cur_err <= 1'b0;
        end else begin
            if ((state == IDLE) && req_any) begin
                cur_err <= req_err;
            end
            err_q <= go_resp & acc_err;
        end
    end

    assign bus.d_mem_err = err_q;
`endif

    // Access sequencer: IDLE -> WAIT (counted) -> RESP -> IDLE, with
    // registered ready and read data.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy_q     <= 1'b0;
            rdata_q   <= 16'h0000;
            cur_idx   <= '0;
            cur_wdata <= 16'h0000;
            cur_op    <= '0;
        end else begin
            rdy_q <= go_resp;
            if (go_resp && acc_rd) begin
                rdata_q <= acc_hit ? ram_q : 16'h0000;
            end

            case (state)
                IDLE: begin
                    if (req_any) begin
                        cur_idx   <= bus.d_mem_adr[ADR_BITS-1:0];
                        cur_wdata <= bus.d_mem_wdata;
                        cur_op    <= req_op;
                        cnt       <= WS_INIT;
                        state     <= go_resp ? RESP : WAIT;
                    end
                end

                WAIT: begin
                    if (!req_any) begin
                        // Initiator withdrew: abandon silently.
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (go_resp) begin
                        cnt   <= '0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.d_mem_rdy   = rdy_q;
    assign bus.d_mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT_STATES 0, 1, 3)
// share one clock, reset and stimulus; sel routes the request to one of them.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        a_rst;
    logic [15:0] adr;
    logic [15:0] wdata;
    logic        r;
    logic        w;
    int          sel;

    logic        rdy_m;
    logic [15:0] rdata_m;
    logic        err_m;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus3 ();

    assign bus0.d_mem_adr   = adr;
    assign bus0.d_mem_wdata = wdata;
    assign bus0.d_mem_r     = r & (sel == 0);
    assign bus0.d_mem_w     = w & (sel == 0);
    assign bus1.d_mem_adr   = adr;
    assign bus1.d_mem_wdata = wdata;
    assign bus1.d_mem_r     = r & (sel == 1);
    assign bus1.d_mem_w     = w & (sel == 1);
    assign bus3.d_mem_adr   = adr;
    assign bus3.d_mem_wdata = wdata;
    assign bus3.d_mem_r     = r & (sel == 2);
    assign bus3.d_mem_w     = w & (sel == 2);

    dmem_responder #(.WAIT_STATES(0)) u_ws0 (.clk(clk), .a_rst(a_rst), .bus(bus0));
    dmem_responder #(.WAIT_STATES(1)) u_ws1 (.clk(clk), .a_rst(a_rst), .bus(bus1));
    dmem_responder #(.WAIT_STATES(3)) u_ws3 (.clk(clk), .a_rst(a_rst), .bus(bus3));

    always_comb begin
        case (sel)
            0:       begin rdy_m = bus0.d_mem_rdy; rdata_m = bus0.d_mem_rdata; end
            1:       begin rdy_m = bus1.d_mem_rdy; rdata_m = bus1.d_mem_rdata; end
            default: begin rdy_m = bus3.d_mem_rdy; rdata_m = bus3.d_mem_rdata; end
        endcase
    end

`ifdef DMEM_RESP_ERR_EN
    always_comb begin
        case (sel)
            0:       err_m = bus0.d_mem_err;
            1:       err_m = bus1.d_mem_err;
            default: err_m = bus3.d_mem_err;
        endcase
    end
`else
    assign err_m = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, hold it until ready, then drop it. lat counts cycles
    // from the cycle the request is first presented (cycle 0).
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output int lat,
                          output logic [15:0] data, output logic err);
        adr   = a;
        wdata = d;
        r     = rd;
        w     = wr;
        lat   = -1;
        data  = 16'hxxxx;
        err   = 1'bx;
        for (int n = 0; n < 32; n++) begin
            if (rdy_m === 1'b1) begin
                lat  = n;
                data = rdata_m;
                err  = err_m;
                break;
            end
            tick();
        end
        tick();
        r = 1'b0;
        w = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] data;
        logic        err;
        logic        seen;

        a_rst = 1'b1;
        r     = 1'b0;
        w     = 1'b0;
        adr   = 16'h0000;
        wdata = 16'h0000;
        sel   = 1;
        tick();
        tick();

        // Reset state of every instance.
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            check($sformatf("reset rdy sel%0d", k), 32'(rdy_m), 32'd0);
            check($sformatf("reset rdata sel%0d", k), 32'(rdata_m), 32'h0000);
`ifdef DMEM_RESP_ERR_EN
            check($sformatf("reset err sel%0d", k), 32'(err_m), 32'd0);
`endif
        end
        a_rst = 1'b0;
        sel   = 1;
        tick();

        // WAIT_STATES=1: write then read back.
        access(1'b0, 1'b1, 16'h0012, 16'hBEEF, lat, data, err);
        check("ws1 write lat", lat, 32'd2);
        check("ws1 write rdy width", 32'(rdy_m), 32'd0);
        tick();
        access(1'b1, 1'b0, 16'h0012, 16'h0000, lat, data, err);
        check("ws1 read lat", lat, 32'd2);
        check("ws1 read data", 32'(data), 32'hBEEF);
`ifdef DMEM_RESP_ERR_EN
        check("ws1 read err", 32'(err), 32'd0);
`endif
        tick();

        // Out-of-window write aliasing index 0x12 must be dropped.
        access(1'b0, 1'b1, 16'h0112, 16'hDEAD, lat, data, err);
        check("oow write lat", lat, 32'd2);
        tick();
        access(1'b1, 1'b0, 16'h0012, 16'h0000, lat, data, err);
        check("oow write dropped", 32'(data), 32'hBEEF);
        tick();

        // Out-of-window read returns zero.
        access(1'b1, 1'b0, 16'h0100, 16'h0000, lat, data, err);
        check("oow read lat", lat, 32'd2);
        check("oow read data", 32'(data), 32'h0000);
`ifdef DMEM_RESP_ERR_EN
        check("oow read err", 32'(err), 32'd1);
`endif
        tick();

        // Simultaneous r/w: read, no write.
        access(1'b0, 1'b1, 16'h0005, 16'h1234, lat, data, err);
        tick();
        access(1'b1, 1'b1, 16'h0005, 16'hFFFF, lat, data, err);
        check("rw lat", lat, 32'd2);
        check("rw data", 32'(data), 32'h1234);
`ifdef DMEM_RESP_ERR_EN
        check("rw err", 32'(err), 32'd1);
`endif
        tick();
        access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, data, err);
        check("rw storage unchanged", 32'(data), 32'h1234);
`ifdef DMEM_RESP_ERR_EN
        check("plain read err", 32'(err), 32'd0);
`endif
        tick();

        // WAIT_STATES=0: preload, then back-to-back reads holding r high.
        sel = 0;
        access(1'b0, 1'b1, 16'h0001, 16'h1111, lat, data, err);
        check("ws0 write1 lat", lat, 32'd1);
        tick();
        access(1'b0, 1'b1, 16'h0002, 16'h2222, lat, data, err);
        check("ws0 write2 lat", lat, 32'd1);
        tick();
        adr = 16'h0001;
        r   = 1'b1;
        check("b2b c0 rdy", 32'(rdy_m), 32'd0);
        tick();
        check("b2b c1 rdy", 32'(rdy_m), 32'd1);
        check("b2b c1 data", 32'(rdata_m), 32'h1111);
        tick();
        adr = 16'h0002;
        check("b2b c2 rdy", 32'(rdy_m), 32'd0);
        check("b2b c2 data hold", 32'(rdata_m), 32'h1111);
        tick();
        check("b2b c3 rdy", 32'(rdy_m), 32'd1);
        check("b2b c3 data", 32'(rdata_m), 32'h2222);
        tick();
        r = 1'b0;
        check("b2b c4 rdy", 32'(rdy_m), 32'd0);
        tick();

        // WAIT_STATES=3: preload and read back.
        sel = 2;
        access(1'b0, 1'b1, 16'h0020, 16'hAAAA, lat, data, err);
        check("ws3 write lat", lat, 32'd4);
        tick();
        access(1'b1, 1'b0, 16'h0020, 16'h0000, lat, data, err);
        check("ws3 read lat", lat, 32'd4);
        check("ws3 read data", 32'(data), 32'hAAAA);
        tick();

        // Write withdrawn after two cycles: no ready, no write.
        adr   = 16'h0020;
        wdata = 16'h5555;
        w     = 1'b1;
        seen  = rdy_m;
        tick();
        seen |= rdy_m;
        tick();
        seen |= rdy_m;
        w = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen |= rdy_m;
        end
        check("drop no rdy", 32'(seen), 32'd0);
        check("drop rdata unchanged", 32'(rdata_m), 32'hAAAA);
        access(1'b1, 1'b0, 16'h0020, 16'h0000, lat, data, err);
        check("drop storage unchanged", 32'(data), 32'hAAAA);
        tick();

        // Reset during WAIT of a write: abort, outputs cleared, no write.
        adr   = 16'h0020;
        wdata = 16'h7777;
        w     = 1'b1;
        tick();
        tick();
        a_rst = 1'b1;
        tick();
        check("rst abort rdy", 32'(rdy_m), 32'd0);
        check("rst abort rdata", 32'(rdata_m), 32'h0000);
`ifdef DMEM_RESP_ERR_EN
        check("rst abort err", 32'(err_m), 32'd0);
`endif
        w     = 1'b0;
        a_rst = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            seen |= rdy_m;
        end
        check("rst abort no rdy", 32'(seen), 32'd0);
        access(1'b1, 1'b0, 16'h0020, 16'h0000, lat, data, err);
        check("rst abort lat", lat, 32'd4);
        check("rst abort no write", 32'(data), 32'hAAAA);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
